// File: rtl/alu_ctrl_stage.sv
// Registered ALU control stage: decodes ALUOp/Funct3/Funct7 into the ALU Operation code behind a two-entry skid buffer.
// Optional macro ALU_CTRL_ILLEGAL_CNT_EN adds a saturating 16-bit count of accepted illegal decodes.
module alu_ctrl_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               ALUOp,
  input  logic [2:0]               Funct3,
  input  logic [6:0]               Funct7,
  input  logic [DATA_WIDTH-1:0]    in_SrcA,
  input  logic [DATA_WIDTH-1:0]    in_SrcB,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
  output logic [15:0]              illegal_count,
`endif
  output logic                     illegal
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [OPCODE_LENGTH-1:0] mainOp_q, mainOp_d, skidOp_q, skidOp_d;
  logic                     mainIll_q, mainIll_d, skidIll_q, skidIll_d;
  logic [DATA_WIDTH-1:0]    mainA_q, mainA_d, skidA_q, skidA_d;
  logic [DATA_WIDTH-1:0]    mainB_q, mainB_d, skidB_q, skidB_d;

  logic [OPCODE_LENGTH-1:0] decOp;
  logic                     decIll;
  logic                     inXfer, outXfer;

  always_comb begin
    decOp  = OPCODE_LENGTH'(4'b1111);
    decIll = 1'b1;
    unique case (ALUOp)
      2'b00: begin
        decOp  = OPCODE_LENGTH'(4'b0010);
        decIll = 1'b0;
      end
      2'b01: begin
        if (Funct3 == 3'b000) begin
          decOp  = OPCODE_LENGTH'(4'b1000);
          decIll = 1'b0;
        end else if (Funct3 == 3'b001) begin
          decOp  = OPCODE_LENGTH'(4'b1001);
          decIll = 1'b0;
        end
      end
      2'b10: begin
        if (Funct7 == 7'b0000000 && Funct3 == 3'b000) begin
          decOp  = OPCODE_LENGTH'(4'b0010);
          decIll = 1'b0;
        end else if (Funct7 == 7'b0000000 && Funct3 == 3'b111) begin
          decOp  = OPCODE_LENGTH'(4'b0000);
          decIll = 1'b0;
        end
      end
      default: begin
        decOp  = OPCODE_LENGTH'(4'b1111);
        decIll = 1'b1;
      end
    endcase
  end

  // Handshakes come from registered state only, so out_ready never reaches in_ready combinationally.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign inXfer    = in_valid & in_ready;
  assign outXfer   = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    mainOp_d  = mainOp_q;
    mainIll_d = mainIll_q;
    mainA_d   = mainA_q;
    mainB_d   = mainB_q;
    skidOp_d  = skidOp_q;
    skidIll_d = skidIll_q;
    skidA_d   = skidA_q;
    skidB_d   = skidB_q;
    unique case (state_q)
      EMPTY: begin
        if (inXfer) begin
          state_d   = ONE;
          mainOp_d  = decOp;
          mainIll_d = decIll;
          mainA_d   = in_SrcA;
          mainB_d   = in_SrcB;
        end
      end
      ONE: begin
        if (inXfer && outXfer) begin
          mainOp_d  = decOp;
          mainIll_d = decIll;
          mainA_d   = in_SrcA;
          mainB_d   = in_SrcB;
        end else if (outXfer) begin
          state_d = EMPTY;
        end else if (inXfer) begin
          state_d   = TWO;
          skidOp_d  = decOp;
          skidIll_d = decIll;
          skidA_d   = in_SrcA;
          skidB_d   = in_SrcB;
        end
      end
      TWO: begin
        if (outXfer) begin
          state_d   = ONE;
          mainOp_d  = skidOp_q;
          mainIll_d = skidIll_q;
          mainA_d   = skidA_q;
          mainB_d   = skidB_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= EMPTY;
      mainOp_q  <= '0;
      mainIll_q <= 1'b0;
      mainA_q   <= '0;
      mainB_q   <= '0;
      skidOp_q  <= '0;
      skidIll_q <= 1'b0;
      skidA_q   <= '0;
      skidB_q   <= '0;
    end else begin
      state_q   <= state_d;
      mainOp_q  <= mainOp_d;
      mainIll_q <= mainIll_d;
      mainA_q   <= mainA_d;
      mainB_q   <= mainB_d;
      skidOp_q  <= skidOp_d;
      skidIll_q <= skidIll_d;
      skidA_q   <= skidA_d;
      skidB_q   <= skidB_d;
    end
  end

  assign Operation = mainOp_q;
  assign illegal   = mainIll_q;
  assign SrcA      = mainA_q;
  assign SrcB      = mainB_q;

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
  logic [15:0] illCnt_q, illCnt_d;

  always_comb begin
    illCnt_d = illCnt_q;
    if (inXfer && decIll && illCnt_q != 16'hFFFF) begin
      illCnt_d = illCnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      illCnt_q <= 16'd0;
    end else begin
      illCnt_q <= illCnt_d;
    end
  end

  assign illegal_count = illCnt_q;
`endif

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed self-checking bench for alu_ctrl_stage; inputs change and outputs are sampled 1ns after each rising edge.
// Define ALU_CTRL_ILLEGAL_CNT_EN to also exercise the illegal counter.
module tb_alu_ctrl_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  ALUOp;
  logic [2:0]  Funct3;
  logic [6:0]  Funct7;
  logic [31:0] in_SrcA;
  logic [31:0] in_SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        illegal;
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
  logic [15:0] illegal_count;
`endif

  int checks = 0;
  int errors = 0;

  alu_ctrl_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUOp     (ALUOp),
    .Funct3    (Funct3),
    .Funct7    (Funct7),
    .in_SrcA   (in_SrcA),
    .in_SrcB   (in_SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    .illegal_count (illegal_count),
`endif
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    ALUOp    = op;
    Funct3   = f3;
    Funct7   = f7;
    in_SrcA  = a;
    in_SrcB  = b;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b1, 2'b10, 3'b000, 7'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    step();
    step();
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_operation", 32'(Operation), 32'd0);
    checkOutput("rst_srca", SrcA, 32'd0);
    checkOutput("rst_srcb", SrcB, 32'd0);
    checkOutput("rst_illegal", 32'(illegal), 32'd0);
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    checkOutput("rst_count", 32'(illegal_count), 32'd0);
`endif

    // Single AND transfer
    reset = 1'b0;
    applyStimulus(1'b1, 2'b10, 3'b111, 7'd0, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    step();
    applyStimulus(1'b0, 2'b00, 3'b000, 7'd0, 32'd0, 32'd0);
    checkOutput("and_valid", 32'(out_valid), 32'd1);
    checkOutput("and_op", 32'(Operation), 32'b0000);
    checkOutput("and_srca", SrcA, 32'hF0F0_00FF);
    checkOutput("and_srcb", SrcB, 32'h0FF0_0F0F);
    checkOutput("and_illegal", 32'(illegal), 32'd0);
    step();
    checkOutput("and_drained", 32'(out_valid), 32'd0);

    // Back-to-back stream
    applyStimulus(1'b1, 2'b10, 3'b000, 7'd0, 32'd11, 32'd21);
    step();
    checkOutput("s0_op", 32'(Operation), 32'b0010);
    checkOutput("s0_srca", SrcA, 32'd11);
    applyStimulus(1'b1, 2'b01, 3'b000, 7'd0, 32'd12, 32'd22);
    step();
    checkOutput("s1_op", 32'(Operation), 32'b1000);
    checkOutput("s1_srca", SrcA, 32'd12);
    applyStimulus(1'b1, 2'b01, 3'b001, 7'd0, 32'd13, 32'd23);
    step();
    checkOutput("s2_op", 32'(Operation), 32'b1001);
    checkOutput("s2_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 2'b00, 3'b101, 7'h7F, 32'd14, 32'd24);
    step();
    checkOutput("s3_op", 32'(Operation), 32'b0010);
    checkOutput("s3_srcb", SrcB, 32'd24);
    applyStimulus(1'b0, 2'b00, 3'b000, 7'd0, 32'd0, 32'd0);
    step();
    checkOutput("s_drained", 32'(out_valid), 32'd0);

    // Stall fills the skid entry
    out_ready = 1'b0;
    applyStimulus(1'b1, 2'b00, 3'b000, 7'd0, 32'd1, 32'd101);
    step();
    checkOutput("st0_in_ready", 32'(in_ready), 32'd1);
    checkOutput("st0_srca", SrcA, 32'd1);
    applyStimulus(1'b1, 2'b01, 3'b001, 7'd0, 32'd2, 32'd102);
    step();
    checkOutput("st1_in_ready", 32'(in_ready), 32'd0);
    checkOutput("st1_op_hold", 32'(Operation), 32'b0010);
    checkOutput("st1_srca_hold", SrcA, 32'd1);
    applyStimulus(1'b1, 2'b10, 3'b111, 7'd0, 32'd3, 32'd103);
    step();
    checkOutput("st2_srca_hold", SrcA, 32'd1);
    checkOutput("st2_srcb_hold", SrcB, 32'd101);
    applyStimulus(1'b0, 2'b00, 3'b000, 7'd0, 32'd0, 32'd0);
    out_ready = 1'b1;
    step();
    checkOutput("st3_op", 32'(Operation), 32'b1001);
    checkOutput("st3_srca", SrcA, 32'd2);
    checkOutput("st3_in_ready", 32'(in_ready), 32'd1);
    step();
    checkOutput("st4_drained", 32'(out_valid), 32'd0);

    // Illegal combinations
    applyStimulus(1'b1, 2'b11, 3'b000, 7'd0, 32'd5, 32'd6);
    step();
    checkOutput("il0_op", 32'(Operation), 32'b1111);
    checkOutput("il0_flag", 32'(illegal), 32'd1);
    applyStimulus(1'b1, 2'b10, 3'b000, 7'b0100000, 32'd7, 32'd8);
    step();
    checkOutput("il1_op", 32'(Operation), 32'b1111);
    checkOutput("il1_flag", 32'(illegal), 32'd1);
    applyStimulus(1'b1, 2'b01, 3'b100, 7'd0, 32'd9, 32'd10);
    step();
    checkOutput("il2_op", 32'(Operation), 32'b1111);
    checkOutput("il2_flag", 32'(illegal), 32'd1);
    applyStimulus(1'b0, 2'b00, 3'b000, 7'd0, 32'd0, 32'd0);
    step();
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    checkOutput("il_count", 32'(illegal_count), 32'd3);
`endif

    // Reset while two entries are held
    out_ready = 1'b0;
    applyStimulus(1'b1, 2'b00, 3'b000, 7'd0, 32'hAA, 32'hBB);
    step();
    applyStimulus(1'b1, 2'b01, 3'b000, 7'd0, 32'hCC, 32'hDD);
    step();
    checkOutput("rt_full", 32'(in_ready), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    applyStimulus(1'b0, 2'b00, 3'b000, 7'd0, 32'd0, 32'd0);
    checkOutput("rt_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rt_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rt_op", 32'(Operation), 32'd0);
    checkOutput("rt_srca", SrcA, 32'd0);
    out_ready = 1'b1;
    step();
    checkOutput("rt_no_ghost", 32'(out_valid), 32'd0);

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    checkOutput("rt_count", 32'(illegal_count), 32'd0);
    applyStimulus(1'b1, 2'b11, 3'b000, 7'd0, 32'd0, 32'd0);
    for (int i = 0; i < 65540; i++) begin
      step();
    end
    applyStimulus(1'b0, 2'b00, 3'b000, 7'd0, 32'd0, 32'd0);
    step();
    checkOutput("sat_count", 32'(illegal_count), 32'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
